// File: rtl/exec_mem_unit.sv
// exec_mem_unit: rv32i execute/memory stage -- ALU, byte-enabled word memory and load formatter.
// The ALU result is the data-memory byte address; the preload port wins over stores.
module exec_mem_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            alu_ctrl,
   input  logic                  alu_src,
   input  logic [DATA_WIDTH-1:0] src1,
   input  logic [DATA_WIDTH-1:0] src2,
   input  logic [DATA_WIDTH-1:0] sign_ext,
   input  logic                  mem_write,
   input  logic                  mem_read,
   input  logic [3:0]            byte_enb,
   input  logic [DATA_WIDTH-1:0] w_data,
   input  logic [2:0]            func3,
   input  logic                  ld_enb,
   input  logic [11:0]           ld_addr,
   input  logic [DATA_WIDTH-1:0] ld_dat,
   input  logic [3:0]            ld_byte_enb,
   input  logic [11:0]           debug_addr,
   output logic [DATA_WIDTH-1:0] results,
   output logic                  zero,
   output logic                  res_last_bit,
   output logic [DATA_WIDTH-1:0] r_dat,
   output logic [DATA_WIDTH-1:0] wb_data,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] debug_data
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_WIDTH-1:0] op_b;
   logic [AW-1:0]         rd_idx, wr_idx, dbg_idx;
   logic [3:0]            wr_mask;
   logic [DATA_WIDTH-1:0] wr_dat;
   logic [7:0]            lane_b;
   logic [15:0]           lane_h;
   logic                  one_hot, half_ok;
   logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

   assign op_b = alu_src ? sign_ext : src2;

   always_comb begin
      results = '0;
      case (alu_ctrl)
         4'b0000: results = src1 + op_b;
         4'b0001: results = src1 - op_b;
         4'b0010: results = src1 & op_b;
         4'b0011: results = src1 | op_b;
         4'b0100: results = src1 ^ op_b;
         4'b0101: results = src1 << op_b[4:0];
         4'b0110: results = src1 >> op_b[4:0];
         4'b0111: results = $signed(src1) >>> op_b[4:0];
         4'b1000: results = {{(DATA_WIDTH-1){1'b0}}, $signed(src1) < $signed(op_b)};
         4'b1001: results = {{(DATA_WIDTH-1){1'b0}}, src1 < op_b};
         default: results = '0;
      endcase
   end

   assign zero         = results == '0;
   assign res_last_bit = results[0];

   // Byte addresses drop the lane bits; indices alias modulo DEPTH.
   assign rd_idx  = results[AW+1:2];
   assign dbg_idx = debug_addr[AW+1:2];
   assign wr_idx  = ld_enb ? ld_addr[AW+1:2] : results[AW+1:2];
   assign wr_dat  = ld_enb ? ld_dat : w_data;
   assign wr_mask = ld_enb ? ld_byte_enb : (mem_write ? byte_enb : 4'b0000);

   // Reset low at the edge blocks the write; contents themselves survive reset.
   always_ff @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (rst && wr_mask[b]) mem[wr_idx][b*8 +: 8] <= wr_dat[b*8 +: 8];
   end

   assign r_dat      = (rst && mem_read) ? mem[rd_idx] : '0;
   assign debug_data = mem[dbg_idx];

   assign one_hot = byte_enb == 4'b0001 || byte_enb == 4'b0010 || byte_enb == 4'b0100 || byte_enb == 4'b1000;
   assign half_ok = byte_enb == 4'b0011 || byte_enb == 4'b1100;
   assign lane_b  = byte_enb[3] ? r_dat[31:24] : byte_enb[2] ? r_dat[23:16] : byte_enb[1] ? r_dat[15:8] : r_dat[7:0];
   assign lane_h  = byte_enb[3] ? r_dat[31:16] : r_dat[15:0];

   always_comb begin
      valid   = 1'b0;
      wb_data = '0;
      case (func3)
         3'b000: begin valid = one_hot; wb_data = {{24{lane_b[7]}}, lane_b}; end
         3'b100: begin valid = one_hot; wb_data = {24'b0, lane_b}; end
         3'b001: begin valid = half_ok; wb_data = {{16{lane_h[15]}}, lane_h}; end
         3'b101: begin valid = half_ok; wb_data = {16'b0, lane_h}; end
         3'b010: begin valid = byte_enb == 4'b1111; wb_data = r_dat; end
         default: begin valid = 1'b0; wb_data = '0; end
      endcase
      valid   = valid && rst;
      wb_data = valid ? wb_data : '0;
   end
endmodule

// File: tb/tb_exec_mem_unit.sv
// tb_exec_mem_unit: directed vectors with hand-computed expectations for exec_mem_unit.
module tb_exec_mem_unit;
   logic        clk = 0, rst = 0;
   logic [3:0]  alu_ctrl = 0, byte_enb = 0, ld_byte_enb = 0;
   logic        alu_src = 0, mem_write = 0, mem_read = 0, ld_enb = 0;
   logic [31:0] src1 = 0, src2 = 0, sign_ext = 0, w_data = 0, ld_dat = 0;
   logic [2:0]  func3 = 0;
   logic [11:0] ld_addr = 0, debug_addr = 0;
   logic [31:0] results, r_dat, wb_data, debug_data;
   logic        zero, res_last_bit, valid;
   int          total = 0, bad = 0;

   exec_mem_unit dut (
      .clk(clk), .rst(rst), .alu_ctrl(alu_ctrl), .alu_src(alu_src), .src1(src1), .src2(src2),
      .sign_ext(sign_ext), .mem_write(mem_write), .mem_read(mem_read), .byte_enb(byte_enb),
      .w_data(w_data), .func3(func3), .ld_enb(ld_enb), .ld_addr(ld_addr), .ld_dat(ld_dat),
      .ld_byte_enb(ld_byte_enb), .debug_addr(debug_addr), .results(results), .zero(zero),
      .res_last_bit(res_last_bit), .r_dat(r_dat), .wb_data(wb_data), .valid(valid),
      .debug_data(debug_data)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b, input logic [31:0] exp, input string tag);
      alu_ctrl = c; src1 = a; src2 = b; alu_src = 0;
      #1 check(tag, results, exp);
   endtask

   task automatic set_addr(input logic [31:0] a);
      alu_ctrl = 4'b0000; alu_src = 1; src1 = a; sign_ext = 0;
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
      set_addr(a); w_data = d; byte_enb = m; mem_write = 1;
      @(posedge clk); #1 mem_write = 0;
   endtask

   task automatic dbg(input logic [11:0] a, input logic [31:0] exp, input string tag);
      debug_addr = a;
      #1 check(tag, debug_data, exp);
   endtask

   task automatic load(input logic [2:0] f, input logic [3:0] m, input logic [31:0] exp_d, input logic exp_v, input string tag);
      func3 = f; byte_enb = m;
      #1 check({tag, "_data"}, wb_data, exp_d);
      check({tag, "_valid"}, {31'b0, valid}, {31'b0, exp_v});
   endtask

   initial begin
      mem_read = 1; func3 = 3'b010; byte_enb = 4'b1111;
      #2 check("rst_r_dat", r_dat, 0);
      check("rst_valid", {31'b0, valid}, 0);
      dbg(12'h000, 32'h0, "powerup_dbg0");
      @(negedge clk); rst = 1; mem_read = 0;

      alu(4'b0001, 5, 7, 32'hFFFFFFFE, "sub");
      check("sub_zero", {31'b0, zero}, 0);
      check("sub_lsb", {31'b0, res_last_bit}, 0);
      alu(4'b1000, 5, 7, 32'h1, "slt");
      check("slt_lsb", {31'b0, res_last_bit}, 1);
      alu(4'b1001, 32'hFFFFFFFF, 7, 32'h0, "sltu");
      check("sltu_zero", {31'b0, zero}, 1);
      alu(4'b1000, 32'hFFFFFFFF, 7, 32'h1, "slt_neg");
      alu(4'b0000, 32'hFFFFFFFF, 2, 32'h1, "add_wrap");
      alu(4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, "and");
      alu(4'b0011, 32'hF0F0F0F0, 32'h0F00000F, 32'hFFF0F0FF, "or");
      alu(4'b0100, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, "xor");
      alu(4'b0101, 32'hF0000010, 32'h24, 32'h00000100, "sll");
      alu(4'b0110, 32'hF0000010, 4, 32'h0F000001, "srl");
      alu(4'b0111, 32'hF0000010, 4, 32'hFF000001, "sra");
      alu(4'b1111, 5, 7, 32'h0, "illegal");
      alu_ctrl = 4'b0000; src1 = 0; sign_ext = 3; alu_src = 1;
      #1 check("imm_src", results, 3);

      ld_enb = 1; ld_addr = 0; ld_dat = 0; ld_byte_enb = 4'b1111;
      @(posedge clk); #1 ld_enb = 0;
      store(0, 32'hABABABAB, 4'b0001);
      dbg(12'h000, 32'h000000AB, "st_b0");
      alu_src = 1; src1 = 0; sign_ext = 1; alu_ctrl = 0; w_data = 32'hCDCDCDCD; byte_enb = 4'b0010; mem_write = 1;
      @(posedge clk); #1 mem_write = 0;
      dbg(12'h000, 32'h0000CDAB, "st_b1");
      store(8, 32'hEFEFEFEF, 4'b0001);
      dbg(12'h008, 32'h000000EF, "st_w8");
      store(5, 32'hABABABAB, 4'b0010);
      dbg(12'h004, 32'h0000AB00, "st_w4");
      dbg(12'h00C, 32'h0, "w12_empty");
      store(12'h00C, 32'hEFEFEFEF, 4'b0001);
      dbg(12'h00C, 32'h000000EF, "st_w12");
      store(12'h00C, 32'h12121212, 4'b0000);
      dbg(12'h00C, 32'h000000EF, "zero_mask");
      store(32'h0000_1030, 32'h5A5A5A5A, 4'b1111);
      dbg(12'h030, 32'h5A5A5A5A, "alias_high");

      set_addr(32'h10); w_data = 32'h11111111; byte_enb = 4'b1111; mem_write = 1; mem_read = 1;
      #1 check("rbw_before", r_dat, 0);
      @(posedge clk); #1 mem_write = 0;
      check("rbw_after", r_dat, 32'h11111111);

      set_addr(0);
      load(3'b100, 4'b0001, 32'h000000AB, 1, "lbu");
      load(3'b000, 4'b0010, 32'hFFFFFFCD, 1, "lb");
      load(3'b001, 4'b0011, 32'hFFFFCDAB, 1, "lh");
      load(3'b101, 4'b0011, 32'h0000CDAB, 1, "lhu");
      load(3'b010, 4'b0001, 32'h0, 0, "lw_badmask");
      load(3'b010, 4'b1111, 32'h0000CDAB, 1, "lw");
      load(3'b000, 4'b0011, 32'h0, 0, "lb_badmask");
      load(3'b101, 4'b1100, 32'h0, 1, "lhu_hi");
      load(3'b011, 4'b1111, 32'h0, 0, "bad_func3");
      mem_read = 0;
      load(3'b010, 4'b1111, 32'h0, 1, "noread");
      mem_read = 1;

      set_addr(0); w_data = 32'hFFFFFFFF; byte_enb = 4'b1111; func3 = 3'b010; mem_write = 1; rst = 0;
      #1 check("rst_r_dat0", r_dat, 0);
      check("rst_valid0", {31'b0, valid}, 0);
      @(posedge clk); #1 mem_write = 0;
      dbg(12'h000, 32'h0000CDAB, "rst_blocks_wr");
      rst = 1;
      #1 check("post_rst_read", r_dat, 32'h0000CDAB);

      ld_enb = 1; ld_addr = 12'h020; ld_dat = 32'h12345678; ld_byte_enb = 4'b1111;
      set_addr(32'h24); w_data = 32'hDEADBEEF; byte_enb = 4'b1111; mem_write = 1;
      @(posedge clk); #1 ld_enb = 0; mem_write = 0;
      dbg(12'h020, 32'h12345678, "prio_ld");
      dbg(12'h024, 32'h0, "prio_st_blocked");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
